// File: rtl/intc_vec_if.sv
//------------------------------------------------------------------------------
// intc_vec_if
// CPU-side vectored interrupt port: request, fetch strobe, vector, acknowledge.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface intc_vec_if;
    logic        virq;
    logic        istb;
    logic [15:0] ivec;
    logic        iack;

    modport master (output virq, output ivec, output iack, input istb);
    modport slave  (input virq, input ivec, input iack, output istb);
endinterface

`default_nettype wire

// File: rtl/intc_vec.sv
//------------------------------------------------------------------------------
// intc_vec
// Fixed-priority vectored interrupt controller with one-cycle device acknowledge.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module intc_vec #(
    parameter int          N_IRQ    = 4,
    parameter logic [15:0] SPUR_VEC = 16'o000000
) (
    input  wire logic                 clk_p,
    input  wire logic                 rst_n,
    input  wire logic                 init,
    input  wire logic [N_IRQ-1:0]     irq_req,
    input  wire logic [16*N_IRQ-1:0]  dev_vec,
    output      logic [N_IRQ-1:0]     dev_ack,
    intc_vec_if.master                cpu
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLD    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               virq_q, virq_d;
    logic               iack_q, iack_d;
    logic [15:0]        ivec_q, ivec_d;
    logic [N_IRQ-1:0]   dev_ack_q, dev_ack_d;

    // w_below[i] is set when any lower-index (higher-priority) source requests
    logic [N_IRQ:0]     w_below;
    logic [N_IRQ-1:0]   w_onehot;
    logic [15:0]        w_acc [0:N_IRQ];
    logic               w_any;

    assign w_below[0] = 1'b0;
    assign w_acc[0]   = '0;

    for (genvar i = 0; i < N_IRQ; i++) begin : g_enc
        assign w_below[i+1] = w_below[i] | irq_req[i];
        assign w_onehot[i]  = irq_req[i] & ~w_below[i];
        assign w_acc[i+1]   = w_acc[i] | ({16{w_onehot[i]}} & dev_vec[16*i +: 16]);
    end

    assign w_any = w_below[N_IRQ];

    always_comb begin
        state_d   = state_q;
        virq_d    = virq_q;
        iack_d    = iack_q;
        ivec_d    = ivec_q;
        dev_ack_d = '0;
        case (state_q)
            S_IDLE: begin
                virq_d = w_any;
                if (cpu.istb && virq_q) begin
                    iack_d  = 1'b1;
                    virq_d  = 1'b0;
                    state_d = S_HOLD;
                    if (w_any) begin
                        ivec_d    = {w_acc[N_IRQ][15:2], 2'b00};
                        dev_ack_d = w_onehot;
                    end else begin
                        ivec_d = SPUR_VEC;
                    end
                end
            end
            S_HOLD: begin
                virq_d = 1'b0;
                if (!cpu.istb) begin
                    iack_d  = 1'b0;
                    ivec_d  = '0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                virq_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                virq_d  = 1'b0;
                iack_d  = 1'b0;
                ivec_d  = '0;
                state_d = S_IDLE;
            end
        endcase
        if (init) begin
            state_d   = S_IDLE;
            virq_d    = 1'b0;
            iack_d    = 1'b0;
            ivec_d    = '0;
            dev_ack_d = '0;
        end
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            virq_q    <= 1'b0;
            iack_q    <= 1'b0;
            ivec_q    <= '0;
            dev_ack_q <= '0;
        end else begin
            state_q   <= state_d;
            virq_q    <= virq_d;
            iack_q    <= iack_d;
            ivec_q    <= ivec_d;
            dev_ack_q <= dev_ack_d;
        end
    end

    assign cpu.virq = virq_q;
    assign cpu.iack = iack_q;
    assign cpu.ivec = ivec_q;
    assign dev_ack  = dev_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_intc_vec.sv
//------------------------------------------------------------------------------
// tb_intc_vec
// Directed bench for intc_vec with a per-cycle reference model and literal pins.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_intc_vec;
    localparam int          N    = 4;
    localparam logic [15:0] SPUR = 16'o000774;

    logic             clk_p = 1'b0;
    logic             rst_n;
    logic             init;
    logic [N-1:0]     irq_req;
    logic [16*N-1:0]  dev_vec;
    logic [N-1:0]     dev_ack;

    always #5 clk_p = ~clk_p;

    intc_vec_if cpu ();

    intc_vec #(.N_IRQ(N), .SPUR_VEC(SPUR)) dut (
        .clk_p   (clk_p),
        .rst_n   (rst_n),
        .init    (init),
        .irq_req (irq_req),
        .dev_vec (dev_vec),
        .dev_ack (dev_ack),
        .cpu     (cpu)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_set(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    // Reference model: outstanding-acknowledge flag plus a post-release cool-down count
    bit          m_virq = 1'b0;
    bit          m_iack = 1'b0;
    bit          m_busy = 1'b0;
    logic [15:0] m_ivec = '0;
    logic [N-1:0] m_ack = '0;
    int          m_cool = 0;
    int          m_k;

    always @(posedge clk_p or negedge rst_n) begin
        if (!rst_n || init) begin
            m_virq = 1'b0; m_iack = 1'b0; m_busy = 1'b0;
            m_ivec = '0;   m_ack  = '0;   m_cool = 0;
        end else begin
            m_ack = '0;
            if (m_busy) begin
                if (!cpu.istb) begin
                    m_busy = 1'b0; m_iack = 1'b0; m_ivec = '0; m_cool = 1;
                end
            end else if (m_cool > 0) begin
                m_cool = m_cool - 1;
            end else if (cpu.istb && m_virq) begin
                m_k    = lowest_set(irq_req);
                m_busy = 1'b1;
                m_iack = 1'b1;
                m_virq = 1'b0;
                if (m_k < 0) begin
                    m_ivec = SPUR;
                end else begin
                    m_ivec = dev_vec[m_k*16 +: 16] & 16'hfffc;
                    m_ack[m_k] = 1'b1;
                end
            end else begin
                m_virq = |irq_req;
            end
        end
    end

    always @(negedge clk_p) begin
        if (cmp_en)
            check("cycle {virq,iack,ivec,dev_ack}",
                  {10'b0, cpu.virq, cpu.iack, cpu.ivec, dev_ack},
                  {10'b0, m_virq, m_iack, m_ivec, m_ack});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_p);
    endtask

    initial begin
        rst_n = 1'b1; init = 1'b0; cpu.istb = 1'b0; irq_req = '0; dev_vec = '0;
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        tick(2);
        check("reset outputs", {cpu.virq, cpu.iack, cpu.ivec, dev_ack}, 22'd0);
        rst_n = 1'b1;
        tick(1);

        // single source 2
        dev_vec[2*16 +: 16] = 16'o060; irq_req = 4'b0100;
        tick(1); check("t1 virq", cpu.virq, 1);
        cpu.istb = 1'b1;
        tick(1);
        check("t1 iack", cpu.iack, 1);
        check("t1 ivec", cpu.ivec, 16'o060);
        check("t1 dev_ack", dev_ack, 4'b0100);
        tick(1);
        check("t1 ack pulse end", dev_ack, 4'b0000);
        check("t1 ivec held", cpu.ivec, 16'o060);
        cpu.istb = 1'b0; irq_req = '0;
        tick(1);
        check("t1 iack drop", cpu.iack, 0);
        check("t1 ivec drop", cpu.ivec, 0);
        tick(2);

        // two sources, priority then re-raise
        dev_vec = '0; dev_vec[1*16 +: 16] = 16'o100; dev_vec[3*16 +: 16] = 16'o300;
        irq_req = 4'b1010;
        tick(1); check("t2 virq", cpu.virq, 1);
        cpu.istb = 1'b1;
        tick(1);
        check("t2 ivec src1", cpu.ivec, 16'o100);
        check("t2 dev_ack src1", dev_ack, 4'b0010);
        cpu.istb = 1'b0; irq_req = 4'b1000;
        tick(1); check("t2 iack drop", cpu.iack, 0);
        tick(1); check("t2 virq low in release", cpu.virq, 0);
        tick(1); check("t2 virq re-raised", cpu.virq, 1);
        cpu.istb = 1'b1;
        tick(1);
        check("t2 ivec src3", cpu.ivec, 16'o300);
        check("t2 dev_ack src3", dev_ack, 4'b1000);
        cpu.istb = 1'b0; irq_req = '0;
        tick(3);

        // request vanishes as the strobe arrives
        dev_vec[0 +: 16] = 16'o200; irq_req = 4'b0001;
        tick(1); check("t3 virq", cpu.virq, 1);
        irq_req = '0; cpu.istb = 1'b1;
        tick(1);
        check("t3 spurious iack", cpu.iack, 1);
        check("t3 spurious ivec", cpu.ivec, SPUR);
        check("t3 spurious no ack", dev_ack, 4'b0000);
        cpu.istb = 1'b0;
        tick(3);

        // strobe with no request present
        cpu.istb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("t4 no iack", cpu.iack, 0);
            check("t4 no ivec", cpu.ivec, 0);
        end
        cpu.istb = 1'b0;
        tick(1);

        // low bits masked, then init mid-HOLD
        dev_vec[0 +: 16] = 16'o063; irq_req = 4'b0001;
        tick(1);
        cpu.istb = 1'b1;
        tick(1);
        check("t5 masked ivec", cpu.ivec, 16'o060);
        check("t5 dev_ack src0", dev_ack, 4'b0001);
        init = 1'b1;
        tick(1);
        check("t5 init clears", {cpu.virq, cpu.iack, cpu.ivec, dev_ack}, 22'd0);
        init = 1'b0; cpu.istb = 1'b0;
        tick(1); check("t5 virq after init", cpu.virq, 1);

        // asynchronous reset mid-HOLD
        cpu.istb = 1'b1;
        tick(1); check("t6 iack before reset", cpu.iack, 1);
        #2 rst_n = 1'b0;
        #1 check("t6 async clear", {cpu.virq, cpu.iack, cpu.ivec, dev_ack}, 22'd0);
        tick(1);
        rst_n = 1'b1; irq_req = '0; cpu.istb = 1'b0;
        tick(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
